sar_osr_ctrl: RTL and testbench

SAR_OSR_CTRL -- requirements
Module: sar_osr_ctrl

---
 rtl/sar_pkg.sv | 28 ++
 rtl/sar_osr_ctrl_if.sv | 28 ++
 rtl/sar_bit_search.sv | 87 ++++++++
 rtl/sar_osr_ctrl.sv | 124 ++++++++++++
 tb/tb_sar_osr_ctrl.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sar_pkg.sv
// Shared definitions for the oversampling SAR controller.
//   sar_state_e   : controller FSM states
//   *_MIN / *_MAX : legal parameter limits
//   params_legal  : range check of a WIDTH / LOG2_AVG / SETTLE combination
package sar_pkg;

  localparam int WIDTH_MIN    = 2;
  localparam int WIDTH_MAX    = 12;
  localparam int LOG2_AVG_MIN = 0;
  localparam int LOG2_AVG_MAX = 4;
  localparam int SETTLE_MIN   = 1;
  localparam int SETTLE_MAX   = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_TEST,
    ST_ACC,
    ST_DONE
  } sar_state_e;

  function automatic bit params_legal(input int width, input int log2_avg, input int settle);
    return (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
           (log2_avg >= LOG2_AVG_MIN) && (log2_avg <= LOG2_AVG_MAX) &&
           (settle >= SETTLE_MIN) && (settle <= SETTLE_MAX);
  endfunction

endpackage

// File: rtl/sar_osr_ctrl_if.sv
// Signal bundle between a converter driver (comparator / request side) and
// sar_osr_ctrl.
//   start, cont, cmp                  : driver -> controller
//   sample, dac, result, eoc, busy    : controller -> driver
interface sar_osr_ctrl_if #(
  parameter int WIDTH = 6
) ();

  logic             start;
  logic             cont;
  logic             cmp;
  logic             sample;
  logic [WIDTH-1:0] dac;
  logic [WIDTH-1:0] result;
  logic             eoc;
  logic             busy;

  modport master (
    output start, cont, cmp,
    input  sample, dac, result, eoc, busy
  );

  modport slave (
    input  start, cont, cmp,
    output sample, dac, result, eoc, busy
  );

endinterface

// File: rtl/sar_bit_search.sv
// Single-conversion successive-approximation search, MSB first.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset
//   clear_i : clear code register and stop any search
//   start_i : begin a new search (MSB trial loaded on the next edge)
//   cmp_i   : comparator, 1 = input >= code_o
//   code_o  : code register (trial code while searching, final code after)
//   last_o  : high in the cycle that resolves bit 0
module sar_bit_search
  import sar_pkg::*;
#(
  parameter int WIDTH  = 6,
  parameter int SETTLE = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic             cmp_i,
  output logic [WIDTH-1:0] code_o,
  output logic             last_o
);

  localparam int BIT_W = $clog2(WIDTH_MAX);
  localparam int CNT_W = $clog2(SETTLE_MAX);

  logic [WIDTH-1:0] code_q, code_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;
  logic             settle_end;
  logic [WIDTH-1:0] cur_mask;

  assign settle_end = (cnt_q == CNT_W'(SETTLE - 1));
  assign cur_mask   = WIDTH'(1) << bit_q;
  assign last_o     = active_q && settle_end && (bit_q == '0);
  assign code_o     = code_q;

  always_comb begin
    code_d   = code_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (clear_i) begin
      code_d   = '0;
      bit_d    = '0;
      cnt_d    = '0;
      active_d = 1'b0;
    end else if (start_i) begin
      code_d   = WIDTH'(1) << (WIDTH - 1);
      bit_d    = BIT_W'(WIDTH - 1);
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (settle_end) begin
        // Resolve the current bit, then raise the next lower trial bit.
        if (!cmp_i) begin
          code_d = code_q & ~cur_mask;
        end
        cnt_d = '0;
        if (bit_q == '0) begin
          active_d = 1'b0;
        end else begin
          bit_d  = bit_q - 1'b1;
          code_d = code_d | (cur_mask >> 1);
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      code_q   <= '0;
      bit_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      code_q   <= code_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/sar_osr_ctrl.sv
// Oversampling SAR ADC controller: averages 2^LOG2_AVG binary-search
// conversions per result, single-shot or continuous.
//   clk_i    : clock            rst_i    : synchronous active-high reset
//   start_i  : request (IDLE)   cont_i   : continuous mode, sampled in DONE
//   cmp_i    : comparator       sample_o : track/hold command
//   dac_o    : DAC trial code   result_o : last averaged result
//   eoc_o    : end-of-conversion pulse   busy_o : high outside IDLE
module sar_osr_ctrl
  import sar_pkg::*;
#(
  parameter int WIDTH    = 6,
  parameter int LOG2_AVG = 2,
  parameter int SETTLE   = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             cont_i,
  input  logic             cmp_i,
  output logic             sample_o,
  output logic [WIDTH-1:0] dac_o,
  output logic [WIDTH-1:0] result_o,
  output logic             eoc_o,
  output logic             busy_o
);

  localparam int ACC_W = WIDTH + LOG2_AVG;
  localparam int CNT_W = LOG2_AVG + 1;
  localparam logic [CNT_W-1:0] N_CONV = CNT_W'(2 ** LOG2_AVG);

  if (!params_legal(WIDTH, LOG2_AVG, SETTLE)) begin : g_bad_params
    $error("sar_osr_ctrl: WIDTH, LOG2_AVG or SETTLE out of range");
  end

  sar_state_e       state_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] conv_q;
  logic [CNT_W-1:0] conv_inc;
  logic [WIDTH-1:0] code;
  logic             last;

  // Code register is cleared while ACC consumes it, so it is already zero
  // in SAMPLE, DONE and IDLE and can drive the DAC directly.
  sar_bit_search #(
    .WIDTH  (WIDTH),
    .SETTLE (SETTLE)
  ) u_search (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (state_q == ST_ACC),
    .start_i (state_q == ST_SAMPLE),
    .cmp_i   (cmp_i),
    .code_o  (code),
    .last_o  (last)
  );

  assign dac_o    = code;
  assign acc_sum  = acc_q + ACC_W'(code);
  assign conv_inc = conv_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      conv_q   <= '0;
      result_o <= '0;
      eoc_o    <= 1'b0;
      sample_o <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q  <= ST_SAMPLE;
            acc_q    <= '0;
            conv_q   <= '0;
            sample_o <= 1'b1;
            busy_o   <= 1'b1;
          end
        end
        ST_SAMPLE: begin
          state_q  <= ST_TEST;
          sample_o <= 1'b0;
        end
        ST_TEST: begin
          if (last) begin
            state_q <= ST_ACC;
          end
        end
        ST_ACC: begin
          acc_q  <= acc_sum;
          conv_q <= conv_inc;
          if (conv_inc == N_CONV) begin
            // Result and eoc are registered on entry to DONE so both are
            // visible together during the DONE cycle.
            state_q  <= ST_DONE;
            result_o <= acc_sum[ACC_W-1:LOG2_AVG];
            eoc_o    <= 1'b1;
          end else begin
            state_q  <= ST_SAMPLE;
            sample_o <= 1'b1;
          end
        end
        ST_DONE: begin
          eoc_o <= 1'b0;
          if (cont_i) begin
            state_q  <= ST_SAMPLE;
            acc_q    <= '0;
            conv_q   <= '0;
            sample_o <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_o  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_osr_ctrl.sv
// Self-checking bench for sar_osr_ctrl: comparator models with programmable
// analog inputs, results checked against clamp/average arithmetic and the
// latency N*(2+WIDTH*SETTLE) edges from the start edge to eoc.
module tb_sar_osr_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  sar_osr_ctrl_if #(.WIDTH(6)) ifa ();
  sar_osr_ctrl_if #(.WIDTH(6)) ifb ();
  sar_osr_ctrl_if #(.WIDTH(5)) ifc ();

  sar_osr_ctrl #(.WIDTH(6), .LOG2_AVG(2), .SETTLE(1)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(ifa.start), .cont_i(ifa.cont), .cmp_i(ifa.cmp),
    .sample_o(ifa.sample), .dac_o(ifa.dac), .result_o(ifa.result), .eoc_o(ifa.eoc), .busy_o(ifa.busy)
  );
  sar_osr_ctrl #(.WIDTH(6), .LOG2_AVG(0), .SETTLE(1)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(ifb.start), .cont_i(ifb.cont), .cmp_i(ifb.cmp),
    .sample_o(ifb.sample), .dac_o(ifb.dac), .result_o(ifb.result), .eoc_o(ifb.eoc), .busy_o(ifb.busy)
  );
  sar_osr_ctrl #(.WIDTH(5), .LOG2_AVG(1), .SETTLE(3)) u_dut_c (
    .clk_i(clk), .rst_i(rst), .start_i(ifc.start), .cont_i(ifc.cont), .cmp_i(ifc.cmp),
    .sample_o(ifc.sample), .dac_o(ifc.dac), .result_o(ifc.result), .eoc_o(ifc.eoc), .busy_o(ifc.busy)
  );

  // Comparator models; a new analog value is taken from the queue while
  // the sample-and-hold is tracking.
  int unsigned vin_a = 0, vin_b = 0, vin_c = 0;
  int unsigned vq_a[$];
  int unsigned vq_c[$];
  int cmp_mode_a = 0;

  always_comb ifa.cmp = (cmp_mode_a == 1) ? 1'b1 : (cmp_mode_a == 2) ? 1'b0 : (vin_a >= 32'(ifa.dac));
  always_comb ifb.cmp = (vin_b >= 32'(ifb.dac));
  always_comb ifc.cmp = (vin_c >= 32'(ifc.dac));

  always @(negedge clk) begin
    if (ifa.sample && vq_a.size() > 0) vin_a <= vq_a.pop_front();
    if (ifc.sample && vq_c.size() > 0) vin_c <= vq_c.pop_front();
  end

  function automatic int unsigned clampv(input int unsigned v, input int w);
    int unsigned mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Trial code for bit i: bits above i taken from the answer, bit i set.
  function automatic int unsigned trial(input int unsigned v, input int i);
    return ((v >> (i + 1)) << (i + 1)) | (1 << i);
  endfunction

  task automatic pulse_start_a();
    @(posedge clk); #1 ifa.start = 1'b1;
    @(posedge clk); #1 ifa.start = 1'b0;
  endtask

  task automatic wait_eoc_a(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk); #1;
      if (ifa.eoc) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    checks++; if (ifa.dac !== 6'd0) begin errors++; $display("FAIL reset_dac got %0d exp 0", ifa.dac); end
    checks++; if (ifa.result !== 6'd0) begin errors++; $display("FAIL reset_result got %0d exp 0", ifa.result); end
    checks++; if (ifa.eoc !== 1'b0) begin errors++; $display("FAIL reset_eoc got %0b exp 0", ifa.eoc); end
    checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", ifa.busy); end
    checks++; if (ifa.sample !== 1'b0) begin errors++; $display("FAIL reset_sample got %0b exp 0", ifa.sample); end
  endtask

  task automatic test_single_conv();
    int n = -1;
    vin_b = 37;
    @(posedge clk); #1 ifb.start = 1'b1;
    @(posedge clk); #1 ifb.start = 1'b0;
    checks++; if (ifb.sample !== 1'b1 || ifb.busy !== 1'b1 || ifb.dac !== 6'd0) begin
      errors++; $display("FAIL single_sample got sample=%0b busy=%0b dac=%0d exp 1 1 0", ifb.sample, ifb.busy, ifb.dac);
    end
    for (int i = 5; i >= 0; i--) begin
      @(posedge clk); #1;
      checks++; if (32'(ifb.dac) !== trial(37, i) || ifb.sample !== 1'b0) begin
        errors++; $display("FAIL single_dac bit %0d got %0d exp %0d", i, ifb.dac, trial(37, i));
      end
    end
    for (int e = 7; e <= 20; e++) begin
      @(posedge clk); #1;
      if (ifb.eoc) begin n = e; break; end
    end
    checks++; if (n != 8) begin errors++; $display("FAIL single_latency got %0d exp 8", n); end
    checks++; if (ifb.result !== 6'd37) begin errors++; $display("FAIL single_result got %0d exp 37", ifb.result); end
    checks++; if (ifb.dac !== 6'd0) begin errors++; $display("FAIL single_done_dac got %0d exp 0", ifb.dac); end
    @(posedge clk); #1;
    checks++; if (ifb.eoc !== 1'b0 || ifb.busy !== 1'b0) begin
      errors++; $display("FAIL single_idle got eoc=%0b busy=%0b exp 0 0", ifb.eoc, ifb.busy);
    end
  endtask

  task automatic test_rails();
    int n;
    for (int m = 1; m <= 2; m++) begin
      cmp_mode_a = m;
      pulse_start_a();
      wait_eoc_a(100, n);
      checks++; if (n != 32) begin errors++; $display("FAIL rail%0d_latency got %0d exp 32", m, n); end
      checks++; if (ifa.result !== ((m == 1) ? 6'd63 : 6'd0)) begin
        errors++; $display("FAIL rail%0d_result got %0d exp %0d", m, ifa.result, (m == 1) ? 63 : 0);
      end
      @(posedge clk); #1;
    end
    cmp_mode_a = 0;
  endtask

  task automatic test_average();
    int n;
    vq_a = {10, 11, 11, 12};
    pulse_start_a();
    wait_eoc_a(100, n);
    checks++; if (n != 32) begin errors++; $display("FAIL avg_latency got %0d exp 32", n); end
    checks++; if (ifa.result !== 6'd11) begin errors++; $display("FAIL avg_result got %0d exp 11", ifa.result); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int n;
    int unsigned v, sum;
    for (int it = 0; it < 6; it++) begin
      sum = 0;
      for (int c = 0; c < 4; c++) begin
        v = $urandom_range(0, 70);
        vq_a.push_back(v);
        sum += clampv(v, 6);
      end
      pulse_start_a();
      wait_eoc_a(100, n);
      checks++; if (n != 32) begin errors++; $display("FAIL rand%0d_latency got %0d exp 32", it, n); end
      checks++; if (32'(ifa.result) !== sum / 4) begin
        errors++; $display("FAIL rand%0d_result got %0d exp %0d", it, ifa.result, sum / 4);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_continuous();
    int n;
    int unsigned v;
    int unsigned exp_res[4];
    for (int r = 0; r < 4; r++) begin
      exp_res[r] = 0;
      for (int c = 0; c < 4; c++) begin
        v = $urandom_range(0, 63);
        vq_a.push_back(v);
        exp_res[r] += v;
      end
      exp_res[r] = exp_res[r] / 4;
    end
    ifa.cont = 1'b1;
    pulse_start_a();
    for (int r = 0; r < 4; r++) begin
      wait_eoc_a(100, n);
      checks++; if (n != ((r == 0) ? 32 : (r == 3) ? 23 : 33)) begin
        errors++; $display("FAIL cont%0d_interval got %0d exp %0d", r, n, (r == 0) ? 32 : (r == 3) ? 23 : 33);
      end
      checks++; if (32'(ifa.result) !== exp_res[r]) begin
        errors++; $display("FAIL cont%0d_result got %0d exp %0d", r, ifa.result, exp_res[r]);
      end
      if (r == 2) begin
        repeat (10) @(posedge clk);
        #1 ifa.cont = 1'b0;
      end
    end
    @(posedge clk); #1;
    checks++; if (ifa.busy !== 1'b0 || ifa.eoc !== 1'b0) begin
      errors++; $display("FAIL cont_stop got busy=%0b eoc=%0b exp 0 0", ifa.busy, ifa.eoc);
    end
    wait_eoc_a(60, n);
    checks++; if (n != -1) begin errors++; $display("FAIL cont_extra_eoc got %0d exp none", n); end
    checks++; if (vq_a.size() != 0) begin errors++; $display("FAIL cont_conv_count left %0d exp 0", vq_a.size()); end
  endtask

  task automatic test_reset_mid();
    int n;
    vq_a = {50, 50, 50, 50};
    pulse_start_a();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    checks++; if (ifa.dac !== 6'd0 || ifa.sample !== 1'b0 || ifa.eoc !== 1'b0 || ifa.busy !== 1'b0 || ifa.result !== 6'd0) begin
      errors++; $display("FAIL rstmid_outputs got dac=%0d sample=%0b eoc=%0b busy=%0b result=%0d exp all 0",
                         ifa.dac, ifa.sample, ifa.eoc, ifa.busy, ifa.result);
    end
    vq_a.delete();
    wait_eoc_a(50, n);
    checks++; if (n != -1) begin errors++; $display("FAIL rstmid_eoc got %0d exp none", n); end
    // reset and start together: reset wins
    rst = 1'b1; ifa.start = 1'b1;
    @(posedge clk); #1 rst = 1'b0; ifa.start = 1'b0;
    checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL rst_start_busy got %0b exp 0", ifa.busy); end
    wait_eoc_a(40, n);
    checks++; if (n != -1) begin errors++; $display("FAIL rst_start_eoc got %0d exp none", n); end
    vq_a = {20, 21, 22, 25};
    pulse_start_a();
    wait_eoc_a(100, n);
    checks++; if (n != 32) begin errors++; $display("FAIL rstmid_after_latency got %0d exp 32", n); end
    checks++; if (ifa.result !== 6'd22) begin errors++; $display("FAIL rstmid_after_result got %0d exp 22", ifa.result); end
    @(posedge clk); #1;
  endtask

  task automatic test_busy_start();
    int n = -1;
    vq_a = {40, 41, 43, 44};
    pulse_start_a();
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (ifa.eoc && n < 0) n = i;
      ifa.start = (i == 5 || i == 15 || i == 32);
    end
    ifa.start = 1'b0;
    checks++; if (n != 32) begin errors++; $display("FAIL busy_start_latency got %0d exp 32", n); end
    checks++; if (ifa.result !== 6'd42) begin errors++; $display("FAIL busy_start_result got %0d exp 42", ifa.result); end
    checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle got %0b exp 0", ifa.busy); end
    wait_eoc_a(60, n);
    checks++; if (n != -1) begin errors++; $display("FAIL busy_start_extra got %0d exp none", n); end
  endtask

  task automatic test_settle();
    int n;
    int unsigned v, v0, sum;
    for (int it = 0; it < 3; it++) begin
      sum = 0;
      for (int c = 0; c < 2; c++) begin
        v = $urandom_range(0, 40);
        vq_c.push_back(v);
        sum += clampv(v, 5);
      end
      v0 = clampv(vq_c[0], 5);
      @(posedge clk); #1 ifc.start = 1'b1;
      @(posedge clk); #1 ifc.start = 1'b0;
      n = -1;
      for (int e = 1; e <= 80; e++) begin
        @(posedge clk); #1;
        if (it == 0 && e <= 15) begin
          checks++; if (32'(ifc.dac) !== trial(v0, 4 - (e - 1) / 3)) begin
            errors++; $display("FAIL settle_dac cycle %0d got %0d exp %0d", e, ifc.dac, trial(v0, 4 - (e - 1) / 3));
          end
        end
        if (ifc.eoc) begin n = e; break; end
      end
      checks++; if (n != 34) begin errors++; $display("FAIL settle%0d_latency got %0d exp 34", it, n); end
      checks++; if (32'(ifc.result) !== sum / 2) begin
        errors++; $display("FAIL settle%0d_result got %0d exp %0d", it, ifc.result, sum / 2);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ifa.start = 1'b0; ifa.cont = 1'b0;
    ifb.start = 1'b0; ifb.cont = 1'b0;
    ifc.start = 1'b0; ifc.cont = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_single_conv();
    test_rails();
    test_average();
    test_random();
    test_continuous();
    test_reset_mid();
    test_busy_start();
    test_settle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
